instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage that sits directly upstream of InstructionDecoder.
- Holds the PC and issues word requests to instruction memory over a req/ack handshake.
- Captures each returned word into a decoder-facing register, together with the decoder's enable and the R/I/J type code.
- Applies branch and jump redirects computed with the shift-left-2 and sign-extension rules the datapath already uses.

Parameters:
ADDR_LEN, 32, PC and memory address width
DATA_LEN, 32, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
imem_req  output  1  instruction memory request
imem_addr  output  ADDR_LEN  request address, stable while imem_req=1 and until ack
imem_ack  input  1  request complete; imem_rdata valid in the same cycle
imem_rdata  input  DATA_LEN  returned instruction word
stall  input  1  decoder cannot accept a new instruction; hold instruction
br_taken  input  1  take branch relative to inst_pc
br_offset  input  16  branch immediate, in words
jmp  input  1  take jump
jmp_target  input  26  jump target field
instruction  output  DATA_LEN  instruction to decoder
inst_pc  output  ADDR_LEN  address of instruction
dec_enable  output  1  instruction holds a valid instruction
dec_type  output  2  0=R (opcode 000000), 2=J (opcode 000010/000011), 1=I (all other opcodes)

Behaviour:
- Reset values (async): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0, instruction=0, inst_pc=0, dec_enable=0, dec_type=0, skid buffer empty.
- States:
  - IDLE: req=0. Next state FETCH when stall=0.
  - FETCH: req=1, addr=pc.
  - HOLD: req=0. Skid buffer full.
  - DROP: req=1, addr=abandoned address. Waits for the stale ack.
- Entering FETCH from any state: imem_addr<=pc (registered). imem_addr stays constant until ack.
- FETCH with ack=1 and stall=0:
  - instruction<=rdata, inst_pc<=imem_addr, dec_enable<=1, dec_type from rdata[31:26].
  - pc<=pc+4. Stay in FETCH; next request issues the following cycle.
  - Throughput: one instruction per cycle with zero-wait memory.
- FETCH with ack=1 and stall=1: rdata/addr go to the skid buffer, pc<=pc+4, state goes to HOLD. instruction is unchanged.
- FETCH with ack=0 and stall=0: dec_enable<=0 (bubble). With stall=1, the instruction register holds.
- HOLD: when stall=0, instruction<=skid contents, dec_enable<=1, skid empties, state goes to FETCH.
- Redirect (br_taken or jmp), sampled at the clock edge:
  - Has priority over stall and over a same-cycle ack.
  - jmp has priority over br_taken.
  - Branch target: pc<=inst_pc+4+(sign_extend(br_offset)<<2), modulo 2^ADDR_LEN.
  - Jump target: pc<={(inst_pc+4)[31:28], jmp_target, 2'b00}.
  - Flush: dec_enable<=0, skid emptied; instruction and inst_pc values are don't-care.
  - From FETCH with ack=0: go to DROP. The outstanding request must not be withdrawn.
  - From FETCH with ack=1: the returned data is discarded; go to FETCH at the new pc.
  - From HOLD or IDLE: go to FETCH at the new pc.
- DROP: on ack, data is discarded and state goes to FETCH at the redirected pc. A further redirect while in DROP only updates pc.
- Redirect inputs are ignored when dec_enable=0.
- Reset mid-request: imem_req drops immediately (asynchronous). An ack after reset is ignored because the block is in IDLE.
- pc+4 wraps to 0 at the top of the address space.

Test Plan:
- Reset, stall=0, ack tied to req, memory word = address: imem_addr sequence 0,4,8,12 from cycle 2. instruction/inst_pc follow one cycle later, with dec_enable=1 continuously.
- imem_rdata=0x0000_0820 at addr 0, 0x8C01_0004 at 4, 0x0800_0010 at 8 -> dec_type 0,1,2. A 2-cycle ack delay inserts dec_enable=0 bubbles and holds imem_addr stable.
- stall=1 while ack returns addr 8 -> instruction still holds addr 4, state HOLD, imem_req=0. stall=0 -> instruction=word@8, then the request for 12 issues.
- inst_pc=0x40, br_taken=1, br_offset=0xFFFE -> next imem_addr=0x3C and dec_enable=0 the cycle after. jmp=1 with jmp_target=0x000_0100 -> imem_addr=0x400.
- Redirect while the ack is delayed 3 cycles -> the stale ack is discarded, dec_enable stays 0, and the next request goes to the target.
- Assert rst mid-FETCH -> all outputs return to their reset values immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage feeding InstructionDecoder. Holds the PC, issues word requests
// to instruction memory over a req/ack handshake, and presents each returned
// word to the decoder together with its address, an enable and the R/I/J
// type code. Branch and jump redirects are taken relative to the address of
// the instruction currently held for the decoder.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   imem_req     memory request (high in FETCH and DROP)
//   imem_addr    request address, held constant until imem_ack
//   imem_ack     request complete, imem_rdata valid this cycle
//   imem_rdata   returned instruction word
//   stall        decoder cannot accept a new instruction
//   br_taken     take branch relative to inst_pc
//   br_offset    branch immediate in words (signed)
//   jmp          take jump (priority over br_taken)
//   jmp_target   26-bit jump target field
//   instruction  instruction presented to the decoder
//   inst_pc      address of instruction
//   dec_enable   instruction holds a valid instruction
//   dec_type     0=R, 1=I, 2=J
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                    ADDR_LEN = 32,
    parameter int                    DATA_LEN = 32,
    parameter logic [ADDR_LEN-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [DATA_LEN-1:0] imem_rdata,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [15:0]         br_offset,
    input  logic                jmp,
    input  logic [25:0]         jmp_target,
    output logic [DATA_LEN-1:0] instruction,
    output logic [ADDR_LEN-1:0] inst_pc,
    output logic                dec_enable,
    output logic [1:0]          dec_type
);

    localparam logic [ADDR_LEN-1:0] PC_STEP = ADDR_LEN'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_LEN-1:0]   r_pc;
    logic [ADDR_LEN-1:0]   w_pc_nxt;
    logic [ADDR_LEN-1:0]   w_addr_nxt;

    // Skid buffer: catches a word that returned while the decoder was stalled.
    logic                  r_skid_vld;
    logic [DATA_LEN-1:0]   r_skid_data;
    logic [ADDR_LEN-1:0]   r_skid_pc;

    logic                  w_redirect;
    logic [ADDR_LEN-1:0]   w_inst_seq;
    logic signed [ADDR_LEN-1:0] w_br_ofs;
    logic [ADDR_LEN-1:0]   w_target;

    logic                  w_cap_mem;
    logic                  w_cap_skid;
    logic                  w_to_skid;
    logic                  w_bubble;
    logic                  w_flush;

    // Opcode field -> decoder type code.
    function automatic logic [1:0] f_dec_type(input logic [5:0] op);
        if (op == 6'b000000)
            return 2'd0;
        else if (op == 6'b000010 || op == 6'b000011)
            return 2'd2;
        else
            return 2'd1;
    endfunction

    // A redirect only means something while a real instruction is held.
    assign w_redirect = (br_taken | jmp) & dec_enable;
    assign w_inst_seq = inst_pc + PC_STEP;
    assign w_br_ofs   = {{(ADDR_LEN-18){br_offset[15]}}, br_offset, 2'b00};
    assign w_target   = jmp ? {w_inst_seq[ADDR_LEN-1:28], jmp_target, 2'b00}
                            : w_inst_seq + $unsigned(w_br_ofs);

    // Request is a pure function of state so an async reset withdraws it at once.
    assign imem_req = (r_state == S_FETCH) || (r_state == S_DROP);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = imem_addr;
        w_cap_mem   = 1'b0;
        w_cap_skid  = 1'b0;
        w_to_skid   = 1'b0;
        w_bubble    = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_redirect) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = w_target;
                    w_addr_nxt  = w_target;
                    w_state_nxt = S_FETCH;
                end else if (!stall) begin
                    w_addr_nxt  = r_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_redirect) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = w_target;
                    // An unacked request cannot be withdrawn; wait it out in DROP.
                    if (imem_ack)
                        w_addr_nxt = w_target;
                    else
                        w_state_nxt = S_DROP;
                end else if (imem_ack) begin
                    w_pc_nxt = r_pc + PC_STEP;
                    if (stall) begin
                        w_to_skid   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_cap_mem  = 1'b1;
                        w_addr_nxt = r_pc + PC_STEP;
                    end
                end else if (!stall) begin
                    w_bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_redirect) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = w_target;
                    w_addr_nxt  = w_target;
                    w_state_nxt = S_FETCH;
                end else if (!stall && r_skid_vld) begin
                    w_cap_skid  = 1'b1;
                    w_addr_nxt  = r_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DROP: begin
                if (w_redirect)
                    w_pc_nxt = w_target;
                if (imem_ack) begin
                    w_addr_nxt  = w_pc_nxt;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            imem_addr   <= '0;
            instruction <= '0;
            inst_pc     <= '0;
            dec_enable  <= 1'b0;
            dec_type    <= 2'd0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_pc   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            imem_addr <= w_addr_nxt;

            if (w_cap_mem) begin
                instruction <= imem_rdata;
                inst_pc     <= imem_addr;
                dec_enable  <= 1'b1;
                dec_type    <= f_dec_type(imem_rdata[DATA_LEN-1 -: 6]);
            end else if (w_cap_skid) begin
                instruction <= r_skid_data;
                inst_pc     <= r_skid_pc;
                dec_enable  <= 1'b1;
                dec_type    <= f_dec_type(r_skid_data[DATA_LEN-1 -: 6]);
            end else if (w_flush || w_bubble) begin
                dec_enable <= 1'b0;
            end

            if (w_to_skid) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= imem_rdata;
                r_skid_pc   <= imem_addr;
            end else if (w_flush || w_cap_skid) begin
                r_skid_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jmp;
    logic [25:0] jmp_target;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        dec_enable;
    logic [1:0]  dec_type;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [1:0]  typ;
    } exp_t;
    exp_t exp_q[$];

    int ack_delay = 0;
    int wait_cnt  = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.ADDR_LEN(32), .DATA_LEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .br_taken(br_taken), .br_offset(br_offset), .jmp(jmp), .jmp_target(jmp_target),
        .instruction(instruction), .inst_pc(inst_pc), .dec_enable(dec_enable), .dec_type(dec_type)
    );

    // Memory model: three fixed words, otherwise word = address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0820;
            32'h4:   return 32'h8C01_0004;
            32'h8:   return 32'h0800_0010;
            default: return a;
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = imem_req && (wait_cnt >= ack_delay);

    always @(posedge clk)
        wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] word, input logic [1:0] typ);
        exp_t e;
        e.pc = pc; e.word = word; e.typ = typ;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: an instruction is consumed whenever it is offered and not stalled.
    always @(negedge clk) begin
        if (!rst && dec_enable && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr actual pc=%h word=%h expected none", inst_pc, instruction);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", inst_pc, e.pc);
                chk("sb_word", instruction, e.word);
                chk("sb_type", {30'd0, dec_type}, {30'd0, e.typ});
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_instr"}, instruction, 32'd0);
        chk({tag, "_ipc"}, inst_pc, 32'd0);
        chk({tag, "_en"}, {31'd0, dec_enable}, 32'd0);
        chk({tag, "_type"}, {30'd0, dec_type}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_offset = '0; jmp = 1'b0; jmp_target = '0;

        // Expected decoder stream, in consumption order.
        push(32'h0, 32'h0000_0820, 2'd0);
        push(32'h4, 32'h8C01_0004, 2'd1);
        push(32'h8, 32'h0800_0010, 2'd2);
        push(32'hC, 32'hC, 2'd0);
        push(32'h10, 32'h10, 2'd0);
        for (int a = 32'h14; a <= 32'h40; a += 4) push(32'(a), 32'(a), 2'd0);
        push(32'h3C, 32'h3C, 2'd0);
        push(32'h400, 32'h400, 2'd0);
        push(32'h444, 32'h444, 2'd0);
        push(32'h0, 32'h0000_0820, 2'd0);

        repeat (2) tick();
        chk_reset("rst");
        rst = 1'b0;

        // Zero-wait streaming
        tick(); chk("a0_req", {31'd0, imem_req}, 32'd1); chk("a0", imem_addr, 32'h0);
        chk("a0_en", {31'd0, dec_enable}, 32'd0);
        tick(); chk("a4", imem_addr, 32'h4); chk("a4_en", {31'd0, dec_enable}, 32'd1);
        tick(); chk("a8", imem_addr, 32'h8);
        tick(); chk("a12", imem_addr, 32'hC);
        ack_delay = 2;

        // Delayed ack: bubbles, address held
        tick(); chk("wait1_addr", imem_addr, 32'hC); chk("wait1_en", {31'd0, dec_enable}, 32'd0);
        tick(); chk("wait2_addr", imem_addr, 32'hC); chk("wait2_en", {31'd0, dec_enable}, 32'd0);
        tick(); chk("wait_done_instr", instruction, 32'hC); chk("wait_done_addr", imem_addr, 32'h10);
        ack_delay = 0;
        stall = 1'b1;

        // Stall while word @0x10 returns -> HOLD
        tick(); chk("hold1_req", {31'd0, imem_req}, 32'd0); chk("hold1_instr", instruction, 32'hC);
        tick(); chk("hold2_req", {31'd0, imem_req}, 32'd0); chk("hold2_instr", instruction, 32'hC);
        stall = 1'b0;
        tick(); chk("unhold_instr", instruction, 32'h10); chk("unhold_req", {31'd0, imem_req}, 32'd1);
        chk("unhold_addr", imem_addr, 32'h14);

        repeat (12) tick();
        chk("at40_ipc", inst_pc, 32'h40); chk("at40_addr", imem_addr, 32'h44);

        // Backward branch: 0x44 - 8 = 0x3C
        br_taken = 1'b1; br_offset = 16'hFFFE;
        tick(); chk("br_addr", imem_addr, 32'h3C); chk("br_en", {31'd0, dec_enable}, 32'd0);
        br_taken = 1'b0;
        tick(); chk("br_instr", instruction, 32'h3C);

        // Jump: {upper4(0x40), 0x100, 00} = 0x400
        jmp = 1'b1; jmp_target = 26'h100;
        tick(); chk("jmp_addr", imem_addr, 32'h400); chk("jmp_en", {31'd0, dec_enable}, 32'd0);
        jmp = 1'b0;
        tick(); chk("jmp_instr", instruction, 32'h400); chk("jmp_next", imem_addr, 32'h404);

        // Redirect with an outstanding request: 0x404 + 0x40 = 0x444
        ack_delay = 3;
        br_taken = 1'b1; br_offset = 16'h0010;
        tick(); br_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drop_addr", imem_addr, 32'h404);
            chk("drop_req", {31'd0, imem_req}, 32'd1);
            chk("drop_en", {31'd0, dec_enable}, 32'd0);
            if (i < 2) tick();
        end
        tick(); chk("drop_tgt", imem_addr, 32'h444); chk("drop_tgt_en", {31'd0, dec_enable}, 32'd0);
        ack_delay = 0;
        tick(); chk("tgt_instr", instruction, 32'h444); chk("tgt_en", {31'd0, dec_enable}, 32'd1);
        ack_delay = 5;

        // Asynchronous reset in the middle of a request
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk_reset("async");
        @(posedge clk); #1;
        rst = 1'b0; ack_delay = 0;
        tick(); chk("restart_addr", imem_addr, 32'h0); chk("restart_req", {31'd0, imem_req}, 32'd1);
        tick(); chk("restart_instr", instruction, 32'h0000_0820);
        @(negedge clk); #1;
        stall = 1'b1;
        repeat (3) tick();
        chk("queue_left", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
